// File: rtl/debug_dumper_if.sv
// rtl/debug_dumper_if.sv - processor debug port plus captured-word stream between dumper and sink
interface debug_dumper_if;
   logic [9:0]  derreference;
   logic [1:0]  select;
   logic [31:0] word;
   logic [31:0] out_data;
   logic [9:0]  out_index;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output derreference, select, out_data, out_index, out_valid,
      input  word, out_ready
   );

   modport slave (
      input  derreference, select, out_data, out_index, out_valid,
      output word, out_ready
   );
endinterface

// File: rtl/debug_dumper.sv
// rtl/debug_dumper.sv - walks a processor debug port over one region and streams each word out
module debug_dumper #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            region,
   input  logic [9:0]            base,
   input  logic [10:0]           count,
   debug_dumper_if.master        dbg,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {IDLE, SETUP, WAIT, CAPTURE, SEND, FINISH} state_t;

   state_t      state, state_nx;
   logic [3:0]  settle_cnt;
   logic [10:0] remaining;
   logic        err_pend;
   logic [10:0] region_size;
   logic [10:0] avail;
   logic [10:0] eff_len;
   logic        base_bad;
   logic        handshake;

   always_comb begin
      region_size = 11'd1024;
      case (region)
         2'd0:    region_size = 11'd256;
         2'd1:    region_size = 11'd32;
         2'd2:    region_size = 11'd2;
         default: region_size = 11'd1024;
      endcase
   end

   // Length is clipped to the end of the region so derreference never wraps.
   assign base_bad  = ({1'b0, base} >= region_size);
   assign avail     = region_size - {1'b0, base};
   assign eff_len   = ((count == 11'd0) || (count > avail)) ? avail : count;
   assign handshake = dbg.out_valid && dbg.out_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = base_bad ? FINISH : SETUP;
         SETUP:   state_nx = WAIT;
         WAIT:    if (settle_cnt <= 4'd1) state_nx = CAPTURE;
         CAPTURE: state_nx = SEND;
         SEND:    if (handshake) state_nx = (remaining == 11'd1) ? FINISH : SETUP;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         settle_cnt       <= 4'd0;
         remaining        <= 11'd0;
         err_pend         <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         dbg.derreference <= 10'd0;
         dbg.select       <= 2'd0;
         dbg.out_data     <= 32'd0;
         dbg.out_index    <= 10'd0;
         dbg.out_valid    <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == FINISH);
         case (state)
            IDLE: begin
               if (start) begin
                  dbg.select       <= region;
                  dbg.derreference <= base;
                  remaining        <= base_bad ? 11'd0 : eff_len;
                  err_pend         <= base_bad;
                  error            <= 1'b0;
               end
            end
            SETUP:   settle_cnt <= 4'(SETTLE_CYCLES);
            WAIT:    settle_cnt <= settle_cnt - 4'd1;
            CAPTURE: begin
               dbg.out_data  <= dbg.word;
               dbg.out_index <= dbg.derreference;
               dbg.out_valid <= 1'b1;
            end
            SEND: begin
               if (handshake) begin
                  dbg.out_valid <= 1'b0;
                  remaining     <= remaining - 11'd1;
                  if (remaining != 11'd1) dbg.derreference <= dbg.derreference + 10'd1;
               end
            end
            // error rises together with the done pulse and holds until the next start.
            FINISH:  error <= err_pend;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dumper.sv
// tb/tb_debug_dumper.sv - directed self-checking bench for debug_dumper
module tb_debug_dumper;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  region;
   logic [9:0]  base;
   logic [10:0] count;
   logic        busy, done, error;

   debug_dumper_if dbg();

   assign dbg.word = {dbg.select ^ 2'd1, 20'd0, dbg.derreference} + 32'h100;

   debug_dumper #(.SETTLE_CYCLES(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .region (region),
      .base   (base),
      .count  (count),
      .dbg    (dbg),
      .busy   (busy),
      .done   (done),
      .error  (error)
   );

   initial forever #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [9:0]  got_idx[$];
   logic [31:0] got_data[$];
   int          done_cnt = 0;
   logic        err_at_done = 1'b0;
   int          deref_viol = 0;
   int          stall_viol = 0;
   int          stall_cycles = 0;
   int          max_idx = 1023;
   int          start_cyc = 0;
   int          first_valid_cyc = -1;
   bit          stall_mode = 1'b0;
   int          lat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [1:0] r, input logic [9:0] i);
      return {r ^ 2'd1, 20'd0, i} + 32'h100;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Sink: always ready, or in stall mode hold ready low for 5 cycles of each valid word.
   initial begin
      int sc;
      sc = 0;
      dbg.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_mode) dbg.out_ready = 1'b1;
         else if (dbg.out_valid) begin
            if (sc < 5) begin
               dbg.out_ready = 1'b0;
               sc++;
            end else dbg.out_ready = 1'b1;
         end else begin
            dbg.out_ready = 1'b0;
            sc = 0;
         end
      end
   end

   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic [9:0]  prev_idx;
      prev_stall = 1'b0;
      prev_data  = 32'd0;
      prev_idx   = 10'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (dbg.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (dbg.out_valid && dbg.out_ready) begin
               got_idx.push_back(dbg.out_index);
               got_data.push_back(dbg.out_data);
            end
            if (dbg.out_valid && !dbg.out_ready) stall_cycles++;
            if (done) begin
               done_cnt++;
               err_at_done = error;
            end
            if (busy && int'(dbg.derreference) > max_idx) deref_viol++;
            if (prev_stall && (!dbg.out_valid || dbg.out_data !== prev_data || dbg.out_index !== prev_idx))
               stall_viol++;
            prev_stall = dbg.out_valid && !dbg.out_ready;
            prev_data  = dbg.out_data;
            prev_idx   = dbg.out_index;
         end else prev_stall = 1'b0;
      end
   end

   task automatic start_dump(input logic [1:0] r, input logic [9:0] b, input logic [10:0] c);
      @(posedge clk);
      #1;
      got_idx.delete();
      got_data.delete();
      done_cnt        = 0;
      stall_cycles    = 0;
      first_valid_cyc = -1;
      case (r)
         2'd0:    max_idx = 255;
         2'd1:    max_idx = 31;
         2'd2:    max_idx = 1;
         default: max_idx = 1023;
      endcase
      region = r;
      base   = b;
      count  = c;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start  = 1'b0;
      region = r + 2'd1;
      base   = b ^ 10'h155;
      count  = c + 11'd5;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 3000) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      if (n >= 3000) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, 32'(dbg.out_valid), 32'd0);
      check({tag, "_data"},  dbg.out_data, 32'd0);
      check({tag, "_index"}, 32'(dbg.out_index), 32'd0);
      check({tag, "_deref"}, 32'(dbg.derreference), 32'd0);
      check({tag, "_select"}, 32'(dbg.select), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      region = 2'd0;
      base   = 10'd0;
      count  = 11'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Whole register region, ready always high.
      start_dump(2'd1, 10'd0, 11'd0);
      wait_done(lat);
      check("r1_words", 32'(got_idx.size()), 32'd32);
      for (int i = 0; i < 32 && i < got_idx.size(); i++) begin
         check("r1_index", 32'(got_idx[i]), 32'(i));
         check("r1_data", got_data[i], 32'h100 + 32'(i));
      end
      check("r1_first_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
      repeat (2) @(negedge clk);
      check("r1_done_pulses", 32'(done_cnt), 32'd1);
      check("r1_error", 32'(err_at_done), 32'd0);
      check("r1_busy_after", 32'(busy), 32'd0);

      // Request crosses end of data memory: clipped to 4 words.
      start_dump(2'd3, 10'd1020, 11'd10);
      wait_done(lat);
      check("r3_words", 32'(got_idx.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_idx.size(); i++) begin
         check("r3_index", 32'(got_idx[i]), 32'd1020 + 32'(i));
         check("r3_data", got_data[i], exp_word(2'd3, 10'(1020 + i)));
      end
      check("r3_deref_range", 32'(deref_viol), 32'd0);
      repeat (2) @(negedge clk);
      check("r3_done_pulses", 32'(done_cnt), 32'd1);

      // Base out of range for hi/lo.
      start_dump(2'd2, 10'd5, 11'd0);
      wait_done(lat);
      check("bad_done_latency", 32'(lat), 32'd2);
      check("bad_error_at_done", 32'(err_at_done), 32'd1);
      check("bad_busy", 32'(busy), 32'd0);
      check("bad_words", 32'(got_idx.size()), 32'd0);
      repeat (3) @(negedge clk);
      check("bad_error_held", 32'(error), 32'd1);
      check("bad_done_pulses", 32'(done_cnt), 32'd1);

      // Backpressure: 5 stalled cycles per word.
      stall_mode = 1'b1;
      start_dump(2'd0, 10'd0, 11'd3);
      wait_done(lat);
      check("stall_words", 32'(got_idx.size()), 32'd3);
      for (int i = 0; i < 3 && i < got_idx.size(); i++) begin
         check("stall_index", 32'(got_idx[i]), 32'(i));
         check("stall_data", got_data[i], exp_word(2'd0, 10'(i)));
      end
      check("stall_stable", 32'(stall_viol), 32'd0);
      check("stall_cycles", 32'(stall_cycles), 32'd15);
      check("stall_error_cleared", 32'(err_at_done), 32'd0);
      stall_mode = 1'b0;
      repeat (2) @(posedge clk);

      // Reset while the second word of an 8-word dump is waiting for handshake.
      start_dump(2'd0, 10'd0, 11'd8);
      begin
         int n;
         n = 0;
         while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (dbg.out_valid && dbg.out_index == 10'd1) break;
         end
         if (n >= 200) check("abort_wait_timeout", 32'd0, 32'd1);
      end
      check("abort_pre_words", 32'(got_idx.size()), 32'd1);
      reset = 1'b0;
      #1;
      check_outputs_zero("abort");
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      start_dump(2'd1, 10'd4, 11'd2);
      wait_done(lat);
      check("restart_words", 32'(got_idx.size()), 32'd2);
      for (int i = 0; i < 2 && i < got_idx.size(); i++) begin
         check("restart_index", 32'(got_idx[i]), 32'd4 + 32'(i));
         check("restart_data", got_data[i], 32'h104 + 32'(i));
      end

      // Start pulse during a running dump must be ignored.
      start_dump(2'd1, 10'd0, 11'd6);
      repeat (3) @(posedge clk);
      #1;
      region = 2'd3;
      base   = 10'd100;
      count  = 11'd0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wait_done(lat);
      check("busy_start_words", 32'(got_idx.size()), 32'd6);
      for (int i = 0; i < 6 && i < got_idx.size(); i++)
         check("busy_start_index", 32'(got_idx[i]), 32'(i));
      repeat (3) @(negedge clk);
      check("busy_start_idle", 32'(busy), 32'd0);
      check("busy_start_done_pulses", 32'(done_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/debug_dumper.md
DEBUG_DUMPER -- requirements
Module: debug_dumper

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1, number of wait cycles between driving an address and capturing word (legal 1..15).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 region  input  2  region to dump: 0 instruction (256 entries), 1 registers (32), 2 hi/lo (2), 3 data memory (1024).
REQ-007 base  input  10  first index to dump; sampled with start.
REQ-008 count  input  11  number of entries requested; sampled with start; 0 means whole region from base.
REQ-009 derreference  output  10  index driven to the processor debug port.
REQ-010 select  output  2  region driven to the processor debug port.
REQ-011 word  input  32  data returned by the debug port for {select, derreference}.
REQ-012 out_data  output  32  captured word.
REQ-013 out_index  output  10  index of out_data.
REQ-014 out_valid  output  1  out_data/out_index valid.
REQ-015 out_ready  input  1  sink accepts when out_valid and out_ready both high on a clock edge.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a dump ends.
REQ-018 error  output  1  held with done and until next accepted start; set when base is out of range.

Function
REQ-019 States: IDLE, SETUP, WAIT, CAPTURE, SEND, FINISH.
REQ-020 IDLE: on start=1, latch region/base/count, drive select=region, derreference=base; go SETUP; else stay.
REQ-021 Region size N: 256, 32, 2, 1024 for region 0..3.
REQ-022 If base >= N: skip transfer, go FINISH with error=1, zero words emitted.
REQ-023 Effective length L = (count==0) ? N-base : min(count, N-base); computed at start, 11-bit unsigned, no overflow.
REQ-024 SETUP: load settle counter with SETTLE_CYCLES; go WAIT.
REQ-025 WAIT: decrement counter each cycle; when it reaches 0 go CAPTURE; derreference/select stable throughout.
REQ-026 CAPTURE: register word into out_data, derreference into out_index; assert out_valid next cycle; go SEND.
REQ-027 SEND: hold out_valid, out_data, out_index stable until handshake; no change while out_ready=0.
REQ-028 On handshake: decrement remaining; if remaining becomes 0 go FINISH, else increment derreference by 1 and go SETUP; out_valid drops the cycle after handshake.
REQ-029 derreference SHALL never exceed N-1 of the latched region; no wrap-around.
REQ-030 Per-word latency from SETUP entry to out_valid = SETTLE_CYCLES+2 cycles, plus sink backpressure.
REQ-031 FINISH: pulse done for exactly one cycle; go IDLE; busy low from next cycle.
REQ-032 start while busy SHALL be ignored; start in same cycle as FINISH SHALL be ignored.
REQ-033 region/base/count changes after start SHALL not affect the running dump.

Reset
REQ-034 reset=0 forces, asynchronously: state IDLE, derreference=0, select=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0, error=0, counters 0.
REQ-035 Reset mid-dump aborts immediately; no done pulse; next dump starts cleanly after reset release.

Verification
REQ-036 region=1, base=0, count=0, out_ready=1, word model returns 0x100+index -> 32 words, out_index 0..31, out_data 0x100..0x11F, one done, error=0.
REQ-037 region=3, base=1020, count=10 -> exactly 4 words indices 1020..1023, derreference never 1024, done pulse.
REQ-038 region=2, base=5 -> zero out_valid, done and error high one cycle after FINISH entry, busy low after.
REQ-039 region=0, base=0, count=3, out_ready low 5 cycles per word -> out_data/out_index stable while stalled, 3 handshakes, indices 0,1,2.
REQ-040 reset asserted during SEND of second word of an 8-word dump -> all outputs zero immediately, no done; new dump region=1, base=4, count=2 emits indices 4,5.
REQ-041 start pulsed while busy -> ignored; running dump length and indices unchanged.
